// File: rtl/imem_arbiter.sv
// imem_arbiter: arbitrates one async-read instruction memory between a fetch
// port and a loader/debug port.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   f_req/f_addr -> f_gnt         fetch request, granted combinationally
//   f_data/f_valid                fetch read data, one cycle after the grant
//   l_req/l_we/l_lock/l_addr/
//   l_wdata -> l_gnt              loader request; l_lock holds the memory
//   l_rdata/l_ack                 loader read data and ack, one cycle after grant
//   m_addr/m_we/m_wdata/m_rdata   memory side
//
// States: SHARE (fetch has priority), LOCK (loader owns the memory),
// DRAIN (one idle cycle after a lock is released).
//
// Build option: define IMEM_ARB_STARVE_EN to add the loader starvation counter.
// Without it, fetch has strict priority in SHARE.

module imem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch port
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic [DATA_WIDTH-1:0] f_data,
  output logic                  f_valid,
  // loader/debug port
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic                  l_lock,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  l_ack,
  // memory side
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_we,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  typedef enum logic [1:0] {StShare, StLock, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   f_data_q, f_data_d;
  logic [DATA_WIDTH-1:0]   l_rdata_q, l_rdata_d;
  logic                    f_valid_q, f_valid_d;
  logic                    l_ack_q, l_ack_d;
  logic                    starve_win;

`ifdef IMEM_ARB_STARVE_EN
  localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  assign starve_win = (wait_cnt_q == CntW'(MAX_WAIT));

  // Counts contested SHARE cycles the loader lost; any loader grant or a
  // dropped request forgets the history.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (l_gnt || !l_req) begin
      wait_cnt_d = '0;
    end else if (state_q == StShare && wait_cnt_q != CntW'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign starve_win = 1'b0;
`endif

  // Grants and next state.
  always_comb begin
    state_d = state_q;
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    unique case (state_q)
      StShare: begin
        if (l_req && (!f_req || starve_win)) begin
          l_gnt = 1'b1;
        end else begin
          f_gnt = f_req;
        end
        if (l_gnt && l_lock) begin
          state_d = StLock;
        end
      end
      StLock: begin
        // The release cycle itself still belongs to the loader.
        l_gnt = l_req;
        if (!l_lock) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StShare;
      end
      default: begin
        state_d = StShare;
      end
    endcase
    // Nothing may reach the memory while reset is held.
    if (!rst_n) begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
    end
  end

  // Memory address holds its last driven value when nobody is granted.
  assign m_addr  = f_gnt ? f_addr : (l_gnt ? l_addr : addr_q);
  assign m_we    = l_gnt & l_we;
  assign m_wdata = l_wdata;

  always_comb begin
    addr_d    = m_addr;
    f_valid_d = f_gnt;
    f_data_d  = f_gnt ? m_rdata : f_data_q;
    l_ack_d   = l_gnt;
    l_rdata_d = (l_gnt && !l_we) ? m_rdata : l_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StShare;
      addr_q    <= '0;
      f_valid_q <= 1'b0;
      f_data_q  <= '0;
      l_ack_q   <= 1'b0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      f_valid_q <= f_valid_d;
      f_data_q  <= f_data_d;
      l_ack_q   <= l_ack_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  assign f_valid = f_valid_q;
  assign f_data  = f_data_q;
  assign l_ack   = l_ack_q;
  assign l_rdata = l_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the arbiter.

module tb_imem_arbiter;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = 4;
  localparam int          Depth = 1 << AW;
`ifdef IMEM_ARB_STARVE_EN
  localparam bit Starve = 1'b1;
`else
  localparam bit Starve = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic [DW-1:0] f_data;
  logic          f_valid;
  logic          l_req;
  logic          l_we;
  logic          l_lock;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic [DW-1:0] l_rdata;
  logic          l_ack;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  // Async-read memory seen by the DUT; written only from the stimulus process.
  logic [DW-1:0] mem [Depth];
  assign m_rdata = mem[m_addr];

  imem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_WAIT  (MW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .f_req  (f_req),
    .f_addr (f_addr),
    .f_gnt  (f_gnt),
    .f_data (f_data),
    .f_valid(f_valid),
    .l_req  (l_req),
    .l_we   (l_we),
    .l_lock (l_lock),
    .l_addr (l_addr),
    .l_wdata(l_wdata),
    .l_gnt  (l_gnt),
    .l_rdata(l_rdata),
    .l_ack  (l_ack),
    .m_addr (m_addr),
    .m_we   (m_we),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Behavioural model: ownership flags, loss counter, expected registered outputs.
  bit            md_lock;
  bit            md_drain;
  int            md_wait;
  logic [AW-1:0] md_addr;
  logic          ex_fv;
  logic [DW-1:0] ex_fd;
  logic          ex_la;
  logic [DW-1:0] ex_lr;
  logic [DW-1:0] ref_mem [Depth];

  // What the DUT did in the last stepped cycle.
  logic obs_fg;
  logic obs_lg;
  logic obs_we;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, advance the model, return just after
  // the rising edge so the caller can drive the next inputs.
  task automatic cycle();
    logic          eg_f;
    logic          eg_l;
    logic          ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] rd;
    bit            in_share;
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    @(negedge clk);
    if (!rst_n) begin
      md_lock  = 1'b0;
      md_drain = 1'b0;
      md_wait  = 0;
      md_addr  = '0;
      ex_fv    = 1'b0;
      ex_fd    = '0;
      ex_la    = 1'b0;
      ex_lr    = '0;
    end
    eg_f     = 1'b0;
    eg_l     = 1'b0;
    in_share = !md_lock && !md_drain;
    if (rst_n && md_lock) begin
      eg_l = l_req;
    end else if (rst_n && in_share) begin
      if (l_req && (!f_req || (Starve && md_wait >= int'(MW)))) eg_l = 1'b1;
      else eg_f = f_req;
    end
    ea  = eg_f ? f_addr : (eg_l ? l_addr : md_addr);
    ewe = eg_l & l_we;

    chk("f_gnt", DW'(f_gnt), DW'(eg_f));
    chk("l_gnt", DW'(l_gnt), DW'(eg_l));
    chk("one_grant", DW'(f_gnt & l_gnt), '0);
    chk("m_addr", DW'(m_addr), DW'(ea));
    chk("m_we", DW'(m_we), DW'(ewe));
    chk("m_wdata", m_wdata, l_wdata);
    chk("f_valid", DW'(f_valid), DW'(ex_fv));
    chk("f_data", f_data, ex_fd);
    chk("l_ack", DW'(l_ack), DW'(ex_la));
    chk("l_rdata", l_rdata, ex_lr);

    obs_fg = f_gnt;
    obs_lg = l_gnt;
    obs_we = m_we;
    wr     = m_we;
    wa     = m_addr;
    wd     = m_wdata;

    if (rst_n) begin
      rd    = ref_mem[ea];
      ex_fv = eg_f;
      if (eg_f) ex_fd = rd;
      ex_la = eg_l;
      if (eg_l && !l_we) ex_lr = rd;
      if (ewe) ref_mem[l_addr] = l_wdata;
      md_addr = ea;
      if (eg_l || !l_req) md_wait = 0;
      else if (in_share) md_wait++;
      if (md_drain) begin
        md_drain = 1'b0;
      end else if (md_lock) begin
        if (!l_lock) begin
          md_lock  = 1'b0;
          md_drain = 1'b1;
        end
      end else if (eg_l && l_lock) begin
        md_lock = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (wr) mem[wa] = wd;
  endtask

  task automatic idle_inputs();
    f_req   = 1'b0;
    f_addr  = '0;
    l_req   = 1'b0;
    l_we    = 1'b0;
    l_lock  = 1'b0;
    l_addr  = '0;
    l_wdata = '0;
  endtask

  initial begin
    logic [DW-1:0] mem7;
    int            first_lg;

    for (int i = 0; i < Depth; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5]     = 32'h8C22_0004;
    ref_mem[5] = 32'h8C22_0004;
    mem7       = mem[7];
    md_lock  = 1'b0;
    md_drain = 1'b0;
    md_wait  = 0;
    md_addr  = '0;
    ex_fv    = 1'b0;
    ex_fd    = '0;
    ex_la    = 1'b0;
    ex_lr    = '0;
    rst_n = 1'b0;
    idle_inputs();

    // Reset values, with a request pending that must not be granted.
    cycle();
    f_req = 1'b1;
    l_req = 1'b1;
    cycle();

    // Fetch of address 5 in the first cycle after reset release.
    rst_n  = 1'b1;
    idle_inputs();
    f_req  = 1'b1;
    f_addr = 6'd5;
    cycle();
    chk("r027_gnt", DW'(obs_fg), DW'(1'b1));
    chk("r027_data", f_data, 32'h8C22_0004);
    chk("r027_valid", DW'(f_valid), DW'(1'b1));
    f_req = 1'b0;
    cycle();

    // Loader write to address 3, then fetch it back.
    l_req   = 1'b1;
    l_we    = 1'b1;
    l_addr  = 6'd3;
    l_wdata = 32'h2008_0001;
    cycle();
    chk("r028_we", DW'(obs_we), DW'(1'b1));
    chk("r028_ack", DW'(l_ack), DW'(1'b1));
    idle_inputs();
    f_req  = 1'b1;
    f_addr = 6'd3;
    cycle();
    chk("r028_we_once", DW'(obs_we), DW'(1'b0));
    chk("r028_fetch", f_data, 32'h2008_0001);
    idle_inputs();
    cycle();

    // Contested read of address 7 against continuous fetch.
    f_req    = 1'b1;
    f_addr   = 6'd9;
    l_req    = 1'b1;
    l_addr   = 6'd7;
    first_lg = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (obs_lg && first_lg == 0) first_lg = k;
    end
    chk("r029_first_lgnt", DW'(first_lg), Starve ? DW'(MW + 1) : '0);
    chk("r029_rdata", l_rdata, Starve ? mem7 : '0);
    idle_inputs();
    cycle();

    // Locked burst of three writes, then release while fetch waits.
    l_req  = 1'b1;
    l_lock = 1'b1;
    l_we   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      l_addr  = AW'(10 + k);
      l_wdata = $urandom;
      cycle();
      chk("r030_lock_fgnt", DW'(obs_fg), DW'(1'b0));
      f_req  = 1'b1;
      f_addr = 6'd11;
    end
    l_req  = 1'b0;
    l_lock = 1'b0;
    l_we   = 1'b0;
    cycle();
    chk("r030_release_fgnt", DW'(obs_fg), DW'(1'b0));
    cycle();
    chk("r030_drain_fgnt", DW'(obs_fg), DW'(1'b0));
    cycle();
    chk("r030_after_fgnt", DW'(obs_fg), DW'(1'b1));
    idle_inputs();
    cycle();

    // Reset during a locked write.
    l_req   = 1'b1;
    l_lock  = 1'b1;
    l_we    = 1'b1;
    l_addr  = 6'd20;
    l_wdata = 32'hDEAD_BEEF;
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("r031_rst_we", DW'(obs_we), DW'(1'b0));
    rst_n  = 1'b1;
    idle_inputs();
    f_req  = 1'b1;
    f_addr = 6'd20;
    cycle();
    chk("r031_fgnt", DW'(obs_fg), DW'(1'b1));
    chk("r031_no_ack", DW'(l_ack), DW'(1'b0));
    idle_inputs();
    cycle();

    // Both ports held for 20 cycles.
    f_req = 1'b1;
    l_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      f_addr = AW'($urandom);
      l_addr = AW'($urandom);
      l_we   = 1'($urandom);
      l_wdata = $urandom;
      cycle();
    end

    // Random traffic with occasional locks and resets.
    for (int k = 0; k < 400; k++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      f_req   = 1'($urandom);
      f_addr  = AW'($urandom);
      l_req   = ($urandom_range(0, 2) != 0);
      l_we    = 1'($urandom);
      l_lock  = ($urandom_range(0, 3) == 0);
      l_addr  = AW'($urandom);
      l_wdata = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, the instruction-memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the instruction/data word width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, the loader starvation limit in cycles.
REQ-004 SHALL have port clk  input  1  the single clock, rising-edge.
REQ-005 SHALL have port rst_n  input  1  the reset, asynchronous, active-low.
REQ-006 SHALL have ports f_req  input  1, f_addr  input  ADDR_WIDTH, f_gnt  output  1, f_data  output  DATA_WIDTH and f_valid  output  1, forming the fetch port.
REQ-007 SHALL have ports l_req  input  1, l_we  input  1, l_lock  input  1, l_addr  input  ADDR_WIDTH, l_wdata  input  DATA_WIDTH, l_gnt  output  1, l_rdata  output  DATA_WIDTH and l_ack  output  1, forming the loader/debug port.
REQ-008 SHALL have ports m_addr  output  ADDR_WIDTH, m_we  output  1, m_wdata  output  DATA_WIDTH and m_rdata  input  DATA_WIDTH, forming the memory side (async-read memory).

Function
REQ-009 SHALL use a three-state FSM: SHARE, LOCK and DRAIN.
REQ-010 SHALL grant at most one of f_gnt/l_gnt per cycle; grants are combinational from the current state and requests.
REQ-011 SHARE: f_req wins by default; l_gnt only when f_req=0 or the starvation rule (REQ-018) fires.
REQ-012 SHARE -> LOCK when l_gnt=1 and l_lock=1 in the same cycle.
REQ-013 LOCK: f_gnt=0 always; l_gnt=l_req; stay while l_lock=1; LOCK -> DRAIN on the first cycle with l_lock=0.
REQ-014 DRAIN: one cycle, no grants, m_we=0; DRAIN -> SHARE unconditionally.
REQ-015 Memory side: m_addr=f_addr when f_gnt, l_addr when l_gnt, else hold the last driven value; m_we=l_gnt&l_we; m_wdata=l_wdata.
REQ-016 Fetch read latency SHALL be 1: on a clock edge with f_gnt=1, register m_rdata into f_data; f_valid=1 the following cycle only.
REQ-017 Loader latency SHALL be 1: an edge with l_gnt=1 sets l_ack=1 for exactly the next cycle; on a read (l_we=0), l_rdata<=m_rdata; on a write, l_rdata is unchanged.
REQ-018 The starvation counter SHALL increment each SHARE cycle with l_req=1 and l_gnt=0, and clear on l_gnt or l_req=0; when it equals MAX_WAIT, the loader wins the next contested SHARE cycle.
REQ-019 f_data/l_rdata SHALL hold their value between transactions.
REQ-020 A request dropped before its grant SHALL be forgotten, with no queued transaction.
REQ-021 If l_req falls while in LOCK with l_lock=1, the state SHALL remain LOCK, no grants are issued, and fetch stays blocked.

Reset
REQ-022 While rst_n=0: state=SHARE, counter=0, f_valid=0, l_ack=0, f_data=0, l_rdata=0, m_addr=0, and all grants and m_we forced to 0.
REQ-023 Reset asserted mid-LOCK or mid-transaction SHALL abort immediately, with no ack/valid issued after release.
REQ-024 The first grant SHALL be possible in the first cycle after rst_n rises.

Configuration
REQ-025 SHALL support macro IMEM_ARB_STARVE_EN: when defined, REQ-018 is active.
REQ-026 When IMEM_ARB_STARVE_EN is undefined, SHALL apply strict fetch priority in SHARE with no counter logic; LOCK/DRAIN behaviour is unchanged.

Verification
REQ-027 Reset, then f_req=1, f_addr=5, with mem[5]=0x8C220004 -> f_gnt=1 in the same cycle; f_valid=1 and f_data=0x8C220004 next cycle.
REQ-028 Loader write of 0x20080001 to address 3, then a fetch of address 3 -> m_we pulses for one cycle, l_ack follows, and fetch returns 0x20080001.
REQ-029 With the macro defined, f_req=1 continuous and l_req=1 read of address 7 -> l_gnt occurs on cycle MAX_WAIT+1=5 and l_rdata=mem[7] one cycle later; with the macro undefined, l_gnt never occurs.
REQ-030 l_req=l_lock=1 for 3 writes, then l_lock=0 while f_req=1 -> no f_gnt during LOCK, f_gnt=0 in DRAIN, and f_gnt=1 on the following cycle.
REQ-031 rst_n pulsed low during LOCK with a write pending -> no m_we after release, state=SHARE, and a fetch is granted on the first cycle after release.
REQ-032 f_req and l_req both held continuously, checked over 20 cycles -> f_gnt and l_gnt are never high together.
